set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter LINE_SIZE, default 16, meaning bytes per line; power of two, at least 4.
REQ-002 Parameter NUM_SETS, default 4, meaning number of sets; power of two.
REQ-003 Parameter NUM_WAYS, default 4, meaning associativity; power of two; NUM_WAYS=1 SHALL behave as direct-mapped.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 is_input_valid  in  1  CPU request strobe, sampled only while is_ready=1.
REQ-007 addr  in  32  byte address: tag | index | offset; word select is offset[OFFSET_BITS-1:2].
REQ-008 mem_read, mem_write  in  1 each  request type; exactly one is high with is_input_valid.
REQ-009 din  in  32  store data.
REQ-010 is_ready  out  1  cache can accept a request this cycle.
REQ-011 is_output_valid  out  1  one-cycle completion pulse for both reads and writes.
REQ-012 dout  out  32  read data; valid only while is_output_valid=1.
REQ-013 is_hit  out  1  lookup hit; meaningful only in COMPARE_TAG.
REQ-014 mem_req_valid, mem_req_read, mem_req_write  out  1 each  line-memory request.
REQ-015 mem_req_addr  out  32-OFFSET_BITS  line address; the byte address shifted right by OFFSET_BITS.
REQ-016 mem_req_din  out  LINE_SIZE*8  writeback line data.
REQ-017 mem_ready  in  1  memory accepts mem_req_valid this cycle.
REQ-018 mem_resp_valid  in  1  fill data valid.
REQ-019 mem_resp_dout  in  LINE_SIZE*8  fill line data.
REQ-020 hit_count, miss_count  out  32 each  saturating performance counters.

Function
REQ-021 The cache SHALL use four states: IDLE, COMPARE_TAG, WRITEBACK and ALLOCATE.
REQ-022 IDLE: is_ready=1; when is_input_valid=1, the cache SHALL latch addr, din and the request type and go to COMPARE_TAG.
REQ-023 After acceptance the cache SHALL use only the latched request; the CPU inputs are don't-care.
REQ-024 COMPARE_TAG: is_hit=1 iff some way of the indexed set is valid and its tag matches; at most one way can match.
REQ-025 Read hit: is_output_valid=1 and dout=the selected word, in the same cycle; next state IDLE. Total latency is 2 cycles from acceptance.
REQ-026 Write hit: the selected word SHALL be updated and the line's dirty bit set at the clock edge; is_output_valid=1; next state IDLE.
REQ-027 Any hit SHALL make the matching way MRU and increment hit_count.
REQ-028 Miss: the cache SHALL increment miss_count (once per request) and choose a victim.
  - Victim SHALL be the lowest-numbered invalid way; otherwise the true-LRU way.
  - Victim SHALL be latched for the rest of the miss.
  - Next state SHALL be WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-029 WRITEBACK: the cache SHALL hold mem_req_valid=1, mem_req_write=1, mem_req_addr={victim tag, index} and mem_req_din=the victim line until mem_ready=1, then go to ALLOCATE.
REQ-030 ALLOCATE, read request: the cache SHALL hold mem_req_valid=1, mem_req_read=1 and the request's line address until mem_ready=1, then drop mem_req_valid and wait for mem_resp_valid.
REQ-031 On mem_resp_valid: the victim way SHALL get data, tag, valid=1 and dirty=0; next state COMPARE_TAG, which then hits.
REQ-032 mem_resp_valid outside ALLOCATE's wait phase SHALL be ignored.
REQ-033 LRU: an age rank of CLOG2(NUM_WAYS) bits per way.
  - On access, ways younger than the accessed way SHALL age by 1; the accessed way SHALL be set to 0.
  - The LRU way is the one with the maximum rank.
  - A fill SHALL count as an access.
REQ-034 Counters SHALL saturate at 32'hFFFF_FFFF and not wrap.
REQ-035 is_ready SHALL be 0 in every state other than IDLE; new requests there SHALL be ignored.

Reset
REQ-036 Reset SHALL return the cache to IDLE with all valid and dirty bits cleared, the LRU ranks set to way number, and counters cleared.
  - Output values at reset: is_output_valid=0, mem_req_valid=0, is_ready=1.
REQ-037 Reset mid-miss SHALL abandon the transaction with no writeback; dirty data is lost.

Structure
REQ-038 State encodings and the CLOG2 macro SHALL come from the shared include.
  - OFFSET_BITS, INDEX_BITS and TAG_BITS SHALL be local parameters.
REQ-039 The LRU ranking SHALL be a sub-module, lru_tracker (per-set ranks, touch port, victim output).

Verification
REQ-040 Cold read of 0x100 (memory responds after 3 cycles) -> one miss, a read request with line address 0x10, then is_output_valid with the correct word; a repeat read hits in 2 cycles.
REQ-041 Write 0xDEADBEEF to 0x104, then read 0x104 -> hit, dout=0xDEADBEEF, no memory traffic.
REQ-042 Five reads mapping to set 0 (NUM_WAYS=4), with the first read again before the fifth -> the victim is the second line, not the first.
REQ-043 Dirty victim eviction -> a writeback with the old tag and line data precedes the fill read; the later re-read of the evicted address returns the written data.
REQ-044 Reset asserted during ALLOCATE -> next cycle is_ready=1, all lines invalid, counters 0.
REQ-045 mem_ready held low for 10 cycles -> the request stays stable, is_ready=0, and hit_count/miss_count are unchanged.

Source files
------------

// File: rtl/set_assoc_cache_pkg.sv
// Shared definitions for the set-associative cache: controller states and
// width helpers used by the top level and the LRU tracker.
package set_assoc_cache_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COMPARE_TAG = 2'd1,
    WRITEBACK   = 2'd2,
    ALLOCATE    = 2'd3
  } state_t;

  localparam int WORD_BITS = 32;

  // Bit width for an index over 'value' items; never narrower than one bit
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// CPU request/response and line-memory handshake bundle for the cache.
// slave = cache side, master = CPU/memory environment side.
interface set_assoc_cache_if #(
  parameter int LINE_SIZE = 16
);
  localparam int OFFSET_BITS = $clog2(LINE_SIZE);

  logic                         is_input_valid;
  logic [31:0]                  addr;
  logic                         mem_read;
  logic                         mem_write;
  logic [31:0]                  din;
  logic                         is_ready;
  logic                         is_output_valid;
  logic [31:0]                  dout;
  logic                         is_hit;
  logic                         mem_req_valid;
  logic                         mem_req_read;
  logic                         mem_req_write;
  logic [31-OFFSET_BITS:0]      mem_req_addr;
  logic [LINE_SIZE*8-1:0]       mem_req_din;
  logic                         mem_ready;
  logic                         mem_resp_valid;
  logic [LINE_SIZE*8-1:0]       mem_resp_dout;
  logic [31:0]                  hit_count;
  logic [31:0]                  miss_count;

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din,
           mem_ready, mem_resp_valid, mem_resp_dout,
    output is_ready, is_output_valid, dout, is_hit,
           mem_req_valid, mem_req_read, mem_req_write, mem_req_addr, mem_req_din,
           hit_count, miss_count
  );

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din,
           mem_ready, mem_resp_valid, mem_resp_dout,
    input  is_ready, is_output_valid, dout, is_hit,
           mem_req_valid, mem_req_read, mem_req_write, mem_req_addr, mem_req_din,
           hit_count, miss_count
  );

endinterface

// File: rtl/set_assoc_cache_lru_tracker.sv
// True-LRU age ranking per set. Rank 0 is most recently used; the way with
// the highest rank is the replacement candidate for the queried set.
module lru_tracker
  import set_assoc_cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 4,
  localparam int SET_W = clog2_min1(NUM_SETS),
  localparam int WAY_W = clog2_min1(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             touch,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [SET_W-1:0] query_set,
  output logic [WAY_W-1:0] victim
);

  logic [WAY_W-1:0] rank [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] best_rank;

  // Touched way becomes youngest; ways younger than it age by one
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          rank[s][w] <= WAY_W'(w);
    end else if (touch) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          rank[touch_set][w] <= '0;
        else if (rank[touch_set][w] < rank[touch_set][touch_way])
          rank[touch_set][w] <= rank[touch_set][w] + 1'b1;
      end
    end
  end

  // Oldest way of the queried set
  always_comb begin
    victim    = '0;
    best_rank = rank[query_set][0];
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (rank[query_set][w] > best_rank) begin
        best_rank = rank[query_set][w];
        victim    = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with true-LRU replacement
// and saturating hit/miss counters. One request in flight at a time.
module set_assoc_cache
  import set_assoc_cache_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS  = 4,
  parameter int NUM_WAYS  = 4
) (
  input logic             clk,
  input logic             reset,
  set_assoc_cache_if.slave bus
);

  localparam int OFFSET_BITS    = $clog2(LINE_SIZE);
  localparam int INDEX_BITS     = $clog2(NUM_SETS);
  localparam int TAG_BITS       = 32 - OFFSET_BITS - INDEX_BITS;
  localparam int LINE_ADDR_BITS = 32 - OFFSET_BITS;
  localparam int LINE_BITS      = LINE_SIZE * 8;
  localparam int WORDS          = LINE_SIZE / 4;
  localparam int SET_W          = clog2_min1(NUM_SETS);
  localparam int WAY_W          = clog2_min1(NUM_WAYS);
  localparam int WORD_SEL_W     = clog2_min1(WORDS);

  state_t state, next_state;

  logic [31:0]      req_addr;
  logic [31:0]      req_din;
  logic             req_write;
  logic [WAY_W-1:0] victim;
  logic             alloc_wait;

  logic [LINE_BITS-1:0] data_mem [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_bits [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_bits [NUM_SETS];

  logic [31:0] hit_count;
  logic [31:0] miss_count;

  logic [LINE_ADDR_BITS-1:0] line_addr;
  logic [SET_W-1:0]          set_idx;
  logic [TAG_BITS-1:0]       req_tag;
  logic [WORD_SEL_W-1:0]     word_sel;

  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 have_invalid;
  logic [WAY_W-1:0]     free_way;
  logic [WAY_W-1:0]     lru_way;
  logic [WAY_W-1:0]     miss_victim;
  logic [LINE_BITS-1:0] hit_line;
  logic [LINE_BITS-1:0] written_line;
  logic [31:0]          hit_word;
  logic                 touch;
  logic [WAY_W-1:0]     touch_way;
  logic                 fill;
  logic                 hit_write;

  assign line_addr = req_addr[31:OFFSET_BITS];
  assign set_idx   = SET_W'(line_addr % NUM_SETS);
  assign req_tag   = TAG_BITS'(line_addr >> INDEX_BITS);
  assign word_sel  = WORD_SEL_W'(req_addr[OFFSET_BITS-1:0] >> 2);

  assign fill      = (state == ALLOCATE) && alloc_wait && bus.mem_resp_valid;
  assign hit_write = (state == COMPARE_TAG) && hit && req_write;

  assign bus.hit_count  = hit_count;
  assign bus.miss_count = miss_count;

  lru_tracker #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) lru (
    .clk       (clk),
    .reset     (reset),
    .touch     (touch),
    .touch_set (set_idx),
    .touch_way (touch_way),
    .query_set (set_idx),
    .victim    (lru_way)
  );

  // Tag lookup across the indexed set, plus lowest-numbered free way
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    have_invalid = 1'b0;
    free_way     = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_bits[set_idx][w] && (tag_mem[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_bits[set_idx][w]) begin
        have_invalid = 1'b1;
        free_way     = WAY_W'(w);
      end
    end
  end

  assign miss_victim = have_invalid ? free_way : lru_way;
  assign hit_line    = data_mem[set_idx][hit_way];
  assign hit_word    = hit_line[word_sel*WORD_BITS +: WORD_BITS];

  // Line image with the store word merged in
  always_comb begin
    written_line = hit_line;
    written_line[word_sel*WORD_BITS +: WORD_BITS] = req_din;
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state, CPU responses, memory requests and LRU touches
  always_comb begin
    next_state          = state;
    bus.is_ready        = 1'b0;
    bus.is_output_valid = 1'b0;
    bus.dout            = '0;
    bus.is_hit          = 1'b0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_read    = 1'b0;
    bus.mem_req_write   = 1'b0;
    bus.mem_req_addr    = line_addr;
    bus.mem_req_din     = '0;
    touch               = 1'b0;
    touch_way           = hit_way;
    case (state)
      IDLE: begin
        bus.is_ready = 1'b1;
        if (bus.is_input_valid) next_state = COMPARE_TAG;
      end
      COMPARE_TAG: begin
        bus.is_hit = hit;
        if (hit) begin
          bus.is_output_valid = 1'b1;
          bus.dout            = hit_word;
          touch               = 1'b1;
          next_state          = IDLE;
        end else if (valid_bits[set_idx][miss_victim] && dirty_bits[set_idx][miss_victim]) begin
          next_state = WRITEBACK;
        end else begin
          next_state = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = (LINE_ADDR_BITS'(tag_mem[set_idx][victim]) << INDEX_BITS)
                            | LINE_ADDR_BITS'(set_idx);
        bus.mem_req_din   = data_mem[set_idx][victim];
        if (bus.mem_ready) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        if (!alloc_wait) begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_read  = 1'b1;
        end else if (bus.mem_resp_valid) begin
          touch      = 1'b1;
          touch_way  = victim;
          next_state = COMPARE_TAG;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the accepted request and track the miss in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr   <= '0;
      req_din    <= '0;
      req_write  <= 1'b0;
      victim     <= '0;
      alloc_wait <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.is_input_valid) begin
        req_addr  <= bus.addr;
        req_din   <= bus.din;
        req_write <= bus.mem_write & ~bus.mem_read;
      end
      if ((state == COMPARE_TAG) && !hit) begin
        victim     <= miss_victim;
        alloc_wait <= 1'b0;
      end
      if ((state == ALLOCATE) && !alloc_wait && bus.mem_ready) alloc_wait <= 1'b1;
      if (fill) alloc_wait <= 1'b0;
    end
  end

  // Valid and dirty bits; reset discards any dirty data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_bits[s] <= '0;
        dirty_bits[s] <= '0;
      end
    end else begin
      if (hit_write) dirty_bits[set_idx][hit_way] <= 1'b1;
      if (fill) begin
        valid_bits[set_idx][victim] <= 1'b1;
        dirty_bits[set_idx][victim] <= 1'b0;
      end
    end
  end

  // Line data and tags need no reset since valid bits gate every use
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (hit_write) data_mem[set_idx][hit_way] <= written_line;
      if (fill) begin
        data_mem[set_idx][victim] <= bus.mem_resp_dout;
        tag_mem[set_idx][victim]  <= req_tag;
      end
    end
  end

  // Saturating counters; the hit that completes a filled miss also counts
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == COMPARE_TAG) begin
      if (hit && (hit_count != 32'hFFFF_FFFF))   hit_count  <= hit_count + 32'd1;
      if (!hit && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed test of set_assoc_cache (16-byte lines, 4 sets, 4 ways) against a
// line memory whose unwritten lines hold word w of line L = 0xA0000000|L<<4|w.
module tb_set_assoc_cache;

  logic clk;
  logic reset;

  set_assoc_cache_if #(.LINE_SIZE(16)) bus ();

  set_assoc_cache #(
    .LINE_SIZE (16),
    .NUM_SETS  (4),
    .NUM_WAYS  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  logic [127:0] mem_store [logic [27:0]];
  int           stall_cycles = 0;
  int           stall_cnt    = 0;
  logic         pending      = 1'b0;
  int           resp_timer   = 0;
  logic [27:0]  resp_line    = '0;
  int           rd_count     = 0;
  int           wb_count     = 0;
  int           seq          = 0;
  int           rd_seq       = 0;
  int           wb_seq       = 0;
  logic [27:0]  rd_addr      = '0;
  logic [27:0]  wb_addr      = '0;
  logic [127:0] wb_data      = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] line;
    if (mem_store.exists(la)) return mem_store[la];
    for (int w = 0; w < 4; w++)
      line[32*w +: 32] = 32'hA000_0000 | ({4'h0, la} << 4) | 32'(w);
    return line;
  endfunction

  // Record memory handshakes at the clock edge
  always @(posedge clk) begin
    if (!reset && bus.mem_req_valid && bus.mem_ready) begin
      seq++;
      if (bus.mem_req_write) begin
        wb_count++;
        wb_seq  = seq;
        wb_addr = bus.mem_req_addr;
        wb_data = bus.mem_req_din;
        mem_store[bus.mem_req_addr] = bus.mem_req_din;
      end else begin
        rd_count++;
        rd_seq     = seq;
        rd_addr    = bus.mem_req_addr;
        pending    = 1'b1;
        resp_timer = 2;
        resp_line  = bus.mem_req_addr;
      end
    end
  end

  // Drive memory ready/response just after each edge
  initial begin
    bus.mem_ready      = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_dout  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready      = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (reset) begin
        pending   = 1'b0;
        stall_cnt = 0;
      end else if (pending) begin
        if (resp_timer == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_dout  = mem_line(resp_line);
          pending            = 1'b0;
        end else begin
          resp_timer--;
        end
      end else if (bus.mem_req_valid) begin
        if (stall_cnt >= stall_cycles) begin
          bus.mem_ready = 1'b1;
          stall_cnt     = 0;
        end else begin
          stall_cnt++;
        end
      end else begin
        stall_cnt = 0;
      end
    end
  end

  task automatic check_output(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", name, obs, exp);
      $error("[TB] check %s did not match", name);
    end
  endtask

  // Present one request in IDLE and let it be accepted
  task automatic apply_stimulus(input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.is_input_valid = 1'b1;
    bus.mem_write      = wr;
    bus.mem_read       = ~wr;
    bus.addr           = a;
    bus.din            = d;
    @(posedge clk);
    #1;
    bus.is_input_valid = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_read       = 1'b0;
    bus.addr           = $urandom;
    bus.din            = $urandom;
  endtask

  // Wait (bounded) for the completion pulse, then step back to IDLE
  task automatic finish_request(output logic [31:0] data, output logic hit,
                                output int cycles, output logic done);
    int i;
    cycles = 2;
    done   = 1'b0;
    data   = '0;
    hit    = 1'b0;
    i      = 0;
    while (!done && i < 300) begin
      if (bus.is_output_valid) begin
        data = bus.dout;
        hit  = bus.is_hit;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cycles++;
        i++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_request(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] data, output logic hit,
                            output int cycles, output logic done);
    apply_stimulus(wr, a, d);
    finish_request(data, hit, cycles, done);
  endtask

  initial begin
    logic [31:0] data;
    logic        hit;
    int          cycles;
    logic        done;
    logic        stable;
    logic        order_ok;

    reset              = 1'b1;
    bus.is_input_valid = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.addr           = '0;
    bus.din            = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_is_ready", bus.is_ready, 1);
    check_output("reset_out_valid", bus.is_output_valid, 0);
    check_output("reset_mem_req_valid", bus.mem_req_valid, 0);
    check_output("reset_hit_count", bus.hit_count, 0);
    check_output("reset_miss_count", bus.miss_count, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // cold read then repeat
    do_request(1'b0, 32'h100, 0, data, hit, cycles, done);
    check_output("cold_done", done, 1);
    check_output("cold_dout", data, 32'hA000_0100);
    check_output("cold_rd_count", rd_count, 1);
    check_output("cold_rd_addr", rd_addr, 28'h10);
    check_output("cold_miss_count", bus.miss_count, 1);
    check_output("cold_hit_count", bus.hit_count, 1);
    do_request(1'b0, 32'h100, 0, data, hit, cycles, done);
    check_output("rehit_hit", hit, 1);
    check_output("rehit_latency", cycles, 2);
    check_output("rehit_dout", data, 32'hA000_0100);
    check_output("rehit_counts", {bus.hit_count, bus.miss_count}, {32'd2, 32'd1});

    // write hit then read back
    do_request(1'b1, 32'h104, 32'hDEAD_BEEF, data, hit, cycles, done);
    check_output("wr_hit", hit, 1);
    check_output("wr_latency", cycles, 2);
    do_request(1'b0, 32'h104, 0, data, hit, cycles, done);
    check_output("rdback_dout", data, 32'hDEAD_BEEF);
    check_output("rdback_traffic", {rd_count, wb_count}, {32'd1, 32'd0});

    // LRU in set 1: A B C D, A again, E evicts B
    do_request(1'b0, 32'h010, 0, data, hit, cycles, done);
    do_request(1'b0, 32'h050, 0, data, hit, cycles, done);
    do_request(1'b0, 32'h090, 0, data, hit, cycles, done);
    do_request(1'b0, 32'h0D0, 0, data, hit, cycles, done);
    check_output("lru_d_dout", data, 32'hA000_00D0);
    do_request(1'b0, 32'h010, 0, data, hit, cycles, done);
    check_output("lru_a_rehit", cycles, 2);
    do_request(1'b0, 32'h110, 0, data, hit, cycles, done);
    check_output("lru_e_dout", data, 32'hA000_0110);
    check_output("lru_e_rd_count", rd_count, 6);
    do_request(1'b0, 32'h010, 0, data, hit, cycles, done);
    check_output("lru_a_kept", {cycles, rd_count}, {32'd2, 32'd6});
    do_request(1'b0, 32'h050, 0, data, hit, cycles, done);
    check_output("lru_b_evicted", {bus.miss_count, rd_count}, {32'd7, 32'd7});
    check_output("lru_b_dout", data, 32'hA000_0050);

    // dirty eviction in set 0
    do_request(1'b0, 32'h400, 0, data, hit, cycles, done);
    do_request(1'b0, 32'h800, 0, data, hit, cycles, done);
    do_request(1'b0, 32'hC00, 0, data, hit, cycles, done);
    check_output("dirty_pre_wb_count", wb_count, 0);
    do_request(1'b0, 32'h1000, 0, data, hit, cycles, done);
    order_ok = (wb_seq < rd_seq);
    check_output("dirty_dout", data, 32'hA000_1000);
    check_output("dirty_wb_count", wb_count, 1);
    check_output("dirty_wb_addr", wb_addr, 28'h10);
    check_output("dirty_wb_data", wb_data, 128'hA000_0103_A000_0102_DEAD_BEEF_A000_0100);
    check_output("dirty_wb_before_fill", order_ok, 1);
    do_request(1'b0, 32'h104, 0, data, hit, cycles, done);
    check_output("dirty_reread_dout", data, 32'hDEAD_BEEF);
    check_output("dirty_reread_counts", {bus.hit_count, bus.miss_count, rd_count},
                 {32'd17, 32'd12, 32'd12});

    // stalled memory; a second request is presented meanwhile and ignored
    stall_cycles = 10;
    apply_stimulus(1'b0, 32'h2000, 0);
    bus.is_input_valid = 1'b1;
    bus.mem_read       = 1'b1;
    bus.addr           = 32'h3000;
    stable             = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      if (!(bus.mem_req_valid === 1'b1 && bus.mem_req_read === 1'b1 &&
            bus.mem_req_addr === 28'h200 && bus.is_ready === 1'b0))
        stable = 1'b0;
    end
    check_output("stall_req_stable", stable, 1);
    check_output("stall_counts", {bus.hit_count, bus.miss_count}, {32'd17, 32'd13});
    check_output("stall_rd_count", rd_count, 12);
    bus.is_input_valid = 1'b0;
    bus.mem_read       = 1'b0;
    finish_request(data, hit, cycles, done);
    stall_cycles = 0;
    check_output("stall_done", done, 1);
    check_output("stall_dout", data, 32'hA000_2000);
    check_output("stall_rd_after", {rd_count, 4'h0, rd_addr}, {32'd13, 32'h200});
    check_output("stall_final_counts", {bus.hit_count, bus.miss_count}, {32'd18, 32'd13});

    // reset while allocating
    stall_cycles = 20;
    apply_stimulus(1'b0, 32'h4000, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_output("midmiss_busy", bus.is_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("midmiss_is_ready", bus.is_ready, 1);
    check_output("midmiss_mem_req_valid", bus.mem_req_valid, 0);
    check_output("midmiss_counts", {bus.hit_count, bus.miss_count}, {32'd0, 32'd0});
    stall_cycles = 0;
    @(posedge clk);
    #1;
    do_request(1'b0, 32'h100, 0, data, hit, cycles, done);
    check_output("after_reset_miss", bus.miss_count, 1);
    check_output("after_reset_dout", data, 32'hA000_0100);
    check_output("after_reset_wb_count", wb_count, 1);
    do_request(1'b0, 32'h2000, 0, data, hit, cycles, done);
    check_output("after_reset_miss2", {bus.hit_count, bus.miss_count}, {32'd2, 32'd2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
